// File: rtl/id_ex_skid_stage_if.sv
// id_ex_skid_stage_if: decode-to-execute handshake bundle, flush and stall counter.
interface id_ex_skid_stage_if #(parameter int DATA_W = 160, parameter int CNT_W = 16);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_count;
  modport master (output in_valid, in_data, flush, out_ready, input in_ready, out_valid, out_data, stall_count);
  modport slave (input in_valid, in_data, flush, out_ready, output in_ready, out_valid, out_data, stall_count);
endinterface

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: registered ID/EX stage with 2-entry skid buffer, flush and saturating stall counter.
module id_ex_skid_stage #(
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_skid_stage_if.slave   bus
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, pop;
  assign bus.in_ready    = state_q != FULL;
  assign bus.out_valid   = state_q != EMPTY;
  assign bus.out_data    = main_q;
  assign bus.stall_count = cnt_q;
  always_comb begin
    accept  = bus.in_valid & bus.in_ready;
    pop     = bus.out_valid & bus.out_ready;
    state_d = bus.flush ? EMPTY :
              state_q == EMPTY ? (accept ? ONE : EMPTY) :
              state_q == ONE ? (accept & ~pop ? FULL : ~accept & pop ? EMPTY : ONE) :
              (pop ? ONE : FULL);
    main_d  = bus.flush ? main_q :
              ((state_q == EMPTY || (state_q == ONE && pop)) && accept) ? bus.in_data :
              (state_q == FULL && pop) ? skid_q : main_q;
    skid_d  = (~bus.flush && state_q == ONE && accept && ~pop) ? bus.in_data : skid_q;
    // Stalls count even in a flush cycle; the counter only clears on reset.
    cnt_d   = (bus.out_valid & ~bus.out_ready & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
